// File: rtl/pattern_gen_if.sv
// rtl/pattern_gen_if.sv - AXI4-Stream bundle between the pattern source and its sink
interface pattern_gen_if #(
    parameter int WIDTH = 32
);
    logic [WIDTH-1:0]   tdata;
    logic [WIDTH/8-1:0] tkeep;
    logic               tvalid;
    logic               tlast;
    logic               tready;

    modport master (
        output tdata,
        output tkeep,
        output tvalid,
        output tlast,
        input  tready
    );

    modport slave (
        input  tdata,
        input  tkeep,
        input  tvalid,
        input  tlast,
        output tready
    );
endinterface

// File: rtl/pattern_gen.sv
// rtl/pattern_gen.sv - AXI4-Stream test-pattern burst source with ap_ctrl_hs control
module pattern_gen #(
    parameter int WIDTH = 32,
    parameter int GAP_W = 8
) (
    input  logic             ap_clk,
    input  logic             ap_rst,
    input  logic             ap_start,
    output logic             ap_ready,
    output logic             ap_idle,
    output logic             ap_done,
    input  logic [31:0]      size,
    input  logic [1:0]       mode,
    input  logic [31:0]      seed,
    input  logic [GAP_W-1:0] gap,
    pattern_gen_if.master    axis
);
    localparam int BYTES = WIDTH / 8;
    localparam logic [7:0] BYTES8 = 8'(BYTES);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_GAP  = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    logic [1:0]       state;
    logic [31:0]      beat_n;
    logic [31:0]      last_idx;
    logic [6:0]       rem_r;
    logic [1:0]       mode_r;
    logic [31:0]      seed_r;
    logic [GAP_W-1:0] gap_r;
    logic [GAP_W-1:0] gap_cnt;
    logic [31:0]      lfsr;

    logic [WIDTH-1:0] tdata_r;
    logic [BYTES-1:0] tkeep_r;
    logic             tvalid_r;
    logic             tlast_r;

    // One Galois step, right-shifting, taps x^32+x^22+x^2+x+1.
    function automatic logic [31:0] lfsr_step(input logic [31:0] l);
        return {1'b0, l[31:1]} ^ (l[0] ? 32'h8020_0003 : 32'h0);
    endfunction

    // Byte enables: all ones, except a partial final beat keeps its low rem bytes.
    function automatic logic [BYTES-1:0] make_keep(input logic is_last, input logic [6:0] rem);
        logic [BYTES-1:0] k;
        k = '1;
        if (is_last && rem != 7'd0)
            k = k >> (BYTES - int'(rem));
        return k;
    endfunction

    // Beat payload for index n; 32-bit word replicated per lane, disabled bytes zeroed.
    function automatic logic [WIDTH-1:0] make_beat(input logic [1:0] m, input logic [31:0] s,
                                                   input logic [31:0] n, input logic [31:0] l,
                                                   input logic [BYTES-1:0] keep);
        logic [WIDTH-1:0] d;
        logic [31:0]      word;
        logic [7:0]       base;
        d    = '0;
        base = s[7:0] + 8'(n[7:0] * BYTES8);
        case (m)
            2'd1:    word = s + n;
            2'd2:    word = l;
            default: word = s;
        endcase
        for (int k = 0; k < BYTES; k++) begin
            if (keep[k])
                d[8*k +: 8] = (m == 2'd0) ? base + 8'(k) : word[8*(k%4) +: 8];
        end
        return d;
    endfunction

    logic [32:0]      start_beats;
    logic [31:0]      start_last_idx;
    logic [6:0]       start_rem;
    logic [31:0]      start_lfsr;
    logic [BYTES-1:0] start_keep;
    logic [WIDTH-1:0] start_data;
    logic [31:0]      nb_n;
    logic [31:0]      nb_lfsr;
    logic [BYTES-1:0] nb_keep;
    logic [WIDTH-1:0] nb_data;

    // First beat built straight from the start inputs; 33-bit sum keeps size=2^32-1 exact.
    always_comb begin
        start_beats    = ({1'b0, size} + 33'(BYTES - 1)) / 33'(BYTES);
        start_last_idx = 32'(start_beats - 33'd1);
        start_rem      = 7'(size % 32'(BYTES));
        start_lfsr     = (seed == 32'd0) ? 32'd1 : seed;
        start_keep     = make_keep(start_last_idx == 32'd0, start_rem);
        start_data     = make_beat(mode, seed, 32'd0, start_lfsr, start_keep);
    end

    // Following beat: from RUN the counters have not yet advanced, from GAP they have.
    always_comb begin
        nb_n    = (state == S_RUN) ? beat_n + 32'd1 : beat_n;
        nb_lfsr = (state == S_RUN) ? lfsr_step(lfsr) : lfsr;
        nb_keep = make_keep(nb_n == last_idx, rem_r);
        nb_data = make_beat(mode_r, seed_r, nb_n, nb_lfsr, nb_keep);
    end

    // Burst control FSM and registered stream outputs.
    always_ff @(posedge ap_clk) begin
        if (ap_rst) begin
            state    <= S_IDLE;
            beat_n   <= '0;
            last_idx <= '0;
            rem_r    <= '0;
            mode_r   <= '0;
            seed_r   <= '0;
            gap_r    <= '0;
            gap_cnt  <= '0;
            lfsr     <= 32'd1;
            tdata_r  <= '0;
            tkeep_r  <= '0;
            tvalid_r <= 1'b0;
            tlast_r  <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (ap_start) begin
                        mode_r   <= mode;
                        seed_r   <= seed;
                        gap_r    <= gap;
                        rem_r    <= start_rem;
                        last_idx <= start_last_idx;
                        beat_n   <= '0;
                        lfsr     <= start_lfsr;
                        if (size == 32'd0) begin
                            state <= S_DONE;
                        end else begin
                            state    <= S_RUN;
                            tvalid_r <= 1'b1;
                            tdata_r  <= start_data;
                            tkeep_r  <= start_keep;
                            tlast_r  <= (start_last_idx == 32'd0);
                        end
                    end
                end
                S_RUN: begin
                    if (tvalid_r && axis.tready) begin
                        beat_n <= beat_n + 32'd1;
                        lfsr   <= lfsr_step(lfsr);
                        if (tlast_r) begin
                            state    <= S_DONE;
                            tvalid_r <= 1'b0;
                            tlast_r  <= 1'b0;
                        end else if (gap_r != '0) begin
                            state    <= S_GAP;
                            tvalid_r <= 1'b0;
                            gap_cnt  <= gap_r;
                        end else begin
                            tdata_r <= nb_data;
                            tkeep_r <= nb_keep;
                            tlast_r <= (nb_n == last_idx);
                        end
                    end
                end
                S_GAP: begin
                    if (gap_cnt == GAP_W'(1)) begin
                        state    <= S_RUN;
                        tvalid_r <= 1'b1;
                        tdata_r  <= nb_data;
                        tkeep_r  <= nb_keep;
                        tlast_r  <= (nb_n == last_idx);
                    end else begin
                        gap_cnt <= gap_cnt - GAP_W'(1);
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    assign ap_idle  = (state == S_IDLE);
    assign ap_ready = (state == S_IDLE) && ap_start;
    assign ap_done  = (state == S_DONE);

    assign axis.tdata  = tdata_r;
    assign axis.tkeep  = tkeep_r;
    assign axis.tvalid = tvalid_r;
    assign axis.tlast  = tlast_r;
endmodule

// File: tb/tb_pattern_gen.sv
// tb/tb_pattern_gen.sv - randomized self-checking bench for pattern_gen
module tb_pattern_gen;
    localparam int WIDTH = 32;
    localparam int GAP_W = 8;

    logic             ap_clk = 1'b0;
    logic             ap_rst;
    logic             ap_start;
    logic             ap_ready;
    logic             ap_idle;
    logic             ap_done;
    logic [31:0]      size;
    logic [1:0]       mode;
    logic [31:0]      seed;
    logic [GAP_W-1:0] gap;

    pattern_gen_if #(.WIDTH(WIDTH)) axis ();

    pattern_gen #(.WIDTH(WIDTH), .GAP_W(GAP_W)) dut (
        .ap_clk   (ap_clk),
        .ap_rst   (ap_rst),
        .ap_start (ap_start),
        .ap_ready (ap_ready),
        .ap_idle  (ap_idle),
        .ap_done  (ap_done),
        .size     (size),
        .mode     (mode),
        .seed     (seed),
        .gap      (gap),
        .axis     (axis)
    );

    always #5 ap_clk = ~ap_clk;

    int errors = 0;
    int checks = 0;

    logic [31:0] exp_data[$];
    logic [3:0]  exp_keep[$];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, want);
        end
    endtask

    function automatic logic [31:0] lfsr_ref(input logic [31:0] l);
        return (l >> 1) ^ (l[0] ? 32'h8020_0003 : 32'h0);
    endfunction

    // Whole burst viewed as a byte stream of length size, cut into 4-byte beats.
    task automatic build_expected(input logic [31:0] sz, input logic [1:0] md, input logic [31:0] sd);
        longint      nbeats;
        logic [31:0] l;
        logic [31:0] word;
        logic [31:0] d;
        logic [3:0]  k;
        longint      j;
        exp_data.delete();
        exp_keep.delete();
        nbeats = (longint'(sz) + 3) / 4;
        l = (sd == 32'd0) ? 32'd1 : sd;
        for (longint b = 0; b < nbeats; b++) begin
            case (md)
                2'd1:    word = sd + 32'(b);
                2'd2:    word = l;
                default: word = sd;
            endcase
            d = '0;
            k = '0;
            for (int bi = 0; bi < 4; bi++) begin
                j = b * 4 + bi;
                if (j < longint'(sz)) begin
                    k[bi] = 1'b1;
                    d[8*bi +: 8] = (md == 2'd0) ? sd[7:0] + 8'(j) : word[8*bi +: 8];
                end
            end
            exp_data.push_back(d);
            exp_keep.push_back(k);
            l = lfsr_ref(l);
        end
    endtask

    task automatic start_burst(input logic [31:0] sz, input logic [1:0] md, input logic [31:0] sd,
                               input logic [7:0] gp);
        @(negedge ap_clk);
        size = sz; mode = md; seed = sd; gap = gp;
        ap_start = 1'b1;
        #1;
        check("ap_ready_on_start", ap_ready, 1'b1);
        @(posedge ap_clk);
        #1;
        ap_start = 1'b0;
        size = $urandom; mode = 2'($urandom); seed = $urandom; gap = 8'($urandom);
    endtask

    task automatic run_burst(input logic [31:0] sz, input logic [1:0] md, input logic [31:0] sd,
                             input logic [7:0] gp, input int rdy_mode, input bit poke);
        int          idx;
        int          low;
        int          cycles;
        int          budget;
        bit          done;
        bit          prev_hold;
        logic [31:0] prev_data;
        logic [3:0]  prev_keep;
        logic        prev_last;
        build_expected(sz, md, sd);
        budget = 100 + exp_data.size() * (int'(gp) + 1) * 10;
        start_burst(sz, md, sd, gp);
        idx = 0; low = 0; cycles = 0; done = 0; prev_hold = 0;
        prev_data = '0; prev_keep = '0; prev_last = 1'b0;
        while (!done && cycles < budget) begin
            @(negedge ap_clk);
            ap_start = 1'b0;
            cycles++;
            case (rdy_mode)
                0:       axis.tready = 1'b1;
                1:       axis.tready = cycles[0];
                default: axis.tready = 1'($urandom_range(0, 1));
            endcase
            if (cycles == 1) begin
                check("first_tvalid", axis.tvalid, sz != 32'd0);
                if (sz == 32'd0) check("size0_done", ap_done, 1'b1);
            end
            if (prev_hold) begin
                check("hold_tvalid", axis.tvalid, 1'b1);
                check("hold_tdata", axis.tdata, prev_data);
                check("hold_tkeep", axis.tkeep, prev_keep);
                check("hold_tlast", axis.tlast, prev_last);
            end
            if (ap_done) begin
                check("beats_at_done", idx, exp_data.size());
                check("tvalid_at_done", axis.tvalid, 1'b0);
                done = 1;
            end else if (axis.tvalid) begin
                if (axis.tready) begin
                    if (idx < exp_data.size()) begin
                        if (gp != 8'd0 && rdy_mode == 0 && idx > 0)
                            check("gap_cycles", low, gp);
                        check("tdata", axis.tdata, exp_data[idx]);
                        check("tkeep", axis.tkeep, exp_keep[idx]);
                        check("tlast", axis.tlast, idx == exp_data.size() - 1);
                    end else begin
                        check("extra_beat", idx, exp_data.size() - 1);
                    end
                    idx++;
                    low = 0;
                end
            end else begin
                low++;
            end
            prev_hold = axis.tvalid && !axis.tready;
            prev_data = axis.tdata;
            prev_keep = axis.tkeep;
            prev_last = axis.tlast;
            if (poke && cycles == 2 && !ap_idle && !ap_done) begin
                ap_start = 1'b1;
                #1;
                check("ready_ignored_busy", ap_ready, 1'b0);
            end
        end
        if (!done) check("done_timeout", 1'b0, 1'b1);
        @(negedge ap_clk);
        ap_start = 1'b0;
        check("done_one_cycle", ap_done, 1'b0);
        check("idle_after_done", ap_idle, 1'b1);
    endtask

    task automatic reset_mid_burst(input logic [31:0] sz);
        int cycles;
        int seen;
        start_burst(sz, 2'd0, $urandom, 8'd0);
        seen = 0;
        cycles = 0;
        axis.tready = 1'b1;
        while (seen < 2 && cycles < 50) begin
            @(negedge ap_clk);
            cycles++;
            if (axis.tvalid) begin
                check("rst_burst_keep", axis.tkeep, 4'hF);
                check("rst_burst_tlast", axis.tlast, 1'b0);
                seen++;
            end
        end
        if (seen < 2) check("rst_burst_timeout", 1'b0, 1'b1);
        ap_rst = 1'b1;
        @(negedge ap_clk);
        check("rst_tvalid", axis.tvalid, 1'b0);
        check("rst_idle", ap_idle, 1'b1);
        check("rst_no_done", ap_done, 1'b0);
        ap_rst = 1'b0;
        @(negedge ap_clk);
        check("rst_no_done_after", ap_done, 1'b0);
        check("rst_tvalid_after", axis.tvalid, 1'b0);
    endtask

    initial begin
        ap_rst = 1'b1; ap_start = 1'b0;
        size = '0; mode = '0; seed = '0; gap = '0;
        axis.tready = 1'b0;
        repeat (3) @(negedge ap_clk);
        check("reset_tvalid", axis.tvalid, 1'b0);
        check("reset_tlast", axis.tlast, 1'b0);
        check("reset_tdata", axis.tdata, 32'd0);
        check("reset_tkeep", axis.tkeep, 4'd0);
        check("reset_done", ap_done, 1'b0);
        check("reset_idle", ap_idle, 1'b1);
        check("reset_ready", ap_ready, 1'b0);
        ap_rst = 1'b0;

        run_burst(32'd8,  2'd0, 32'h80,        8'd0, 0, 1'b0);
        run_burst(32'd6,  2'd0, 32'h80,        8'd0, 0, 1'b0);
        run_burst(32'd0,  2'd0, 32'h80,        8'd0, 0, 1'b0);
        run_burst(32'd12, 2'd1, 32'hFFFF_FFFE, 8'd0, 1, 1'b0);
        run_burst(32'd16, 2'd2, 32'h0,         8'd0, 2, 1'b0);
        run_burst(32'd12, 2'd3, 32'hA5A5_A5A5, 8'd3, 0, 1'b1);

        reset_mid_burst(32'd40);
        run_burst(32'd40, 2'd0, 32'h10, 8'd0, 0, 1'b0);
        reset_mid_burst(32'hFFFF_FFFF);
        run_burst(32'd5, 2'd1, 32'h1234_5678, 8'd1, 0, 1'b1);

        for (int i = 0; i < 30; i++) begin
            run_burst(32'($urandom_range(0, 40)), 2'($urandom), $urandom,
                      8'($urandom_range(0, 3)), int'($urandom_range(0, 2)), 1'b1);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
